// File: rtl/axi_lite_wr_rd_checker.sv
// AXI4-Lite built-in self-test master: writes a generated pattern to a register
// window, reads it back, and reports mismatches, bad responses and phase timeouts.
module axi_lite_wr_rd_checker #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter int                            ADDR_STRIDE        = 4,
    parameter int                            PATTERN_MODE       = 0,
    parameter int                            TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [15:0]                       err_count,
    output logic [7:0]                        first_err_index,
    output logic                              resp_err,
    output logic                              timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Galois taps: x^32+x^22+x^2+x+1 or x^64+x^63+x^61+x^60+1
    localparam logic [DW-1:0] LFSR_MASK = (DW == 64) ? DW'(64'hD800_0000_0000_0000)
                                                     : DW'(64'h0000_0000_8020_0003);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_NEXT, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      idx;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic            aw_done, w_done, err_seen;
    logic [TW-1:0]   tcnt;
    logic            aw_hs, w_hs, phase_done, waiting, expired;
    logic            wr_err, rd_err, last_reg;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
    endfunction

    function automatic logic [DW-1:0] pattern_init(input logic [DW-1:0] s);
        if (PATTERN_MODE == 1 && s == '0) return DW'(1);
        return s;
    endfunction

    function automatic logic [DW-1:0] pattern_next(input logic [DW-1:0] s);
        if (PATTERN_MODE == 1) return lfsr_step(s);
        return s + DW'(1);
    endfunction

    assign aw_hs    = m_axi_awvalid & m_axi_awready;
    assign w_hs     = m_axi_wvalid & m_axi_wready;
    assign last_reg = (idx == 8'(NUM_REGS - 1));
    assign wr_err   = (state == S_WR_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00);
    assign rd_err   = (state == S_RD_DATA) && m_axi_rvalid &&
                      ((m_axi_rresp != 2'b00) || (m_axi_rdata != data_q));

    always_comb begin
        phase_done = 1'b0;
        case (state)
            S_WR:      phase_done = (aw_done | aw_hs) & (w_done | w_hs);
            S_WR_RESP: phase_done = m_axi_bvalid;
            S_RD:      phase_done = m_axi_arready;
            S_RD_DATA: phase_done = m_axi_rvalid;
            default:   phase_done = 1'b0;
        endcase
        waiting = ((state == S_WR) || (state == S_WR_RESP) ||
                   (state == S_RD) || (state == S_RD_DATA)) && !phase_done;
        expired = waiting && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_WR;
            S_WR:      if (expired) state_nxt = S_DONE; else if (phase_done) state_nxt = S_WR_RESP;
            S_WR_RESP: if (expired) state_nxt = S_DONE; else if (phase_done) state_nxt = S_RD;
            S_RD:      if (expired) state_nxt = S_DONE; else if (phase_done) state_nxt = S_RD_DATA;
            S_RD_DATA: if (expired) state_nxt = S_DONE; else if (phase_done) state_nxt = S_NEXT;
            S_NEXT:    state_nxt = last_reg ? S_DONE : S_WR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Valids/readies follow the state, so an async reset or timeout drops them at once.
    always_comb begin
        m_axi_awvalid = (state == S_WR) && !aw_done;
        m_axi_wvalid  = (state == S_WR) && !w_done;
        m_axi_bready  = (state == S_WR_RESP);
        m_axi_arvalid = (state == S_RD);
        m_axi_rready  = (state == S_RD_DATA);
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = data_q;
    assign m_axi_wstrb  = '1;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // DONE is transient: the sweep result is latched and the FSM lands back in IDLE.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state           <= S_IDLE;
            idx             <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            tcnt            <= '0;
            err_seen        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_index <= 8'hFF;
            resp_err        <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state <= (state_nxt == S_DONE) ? S_IDLE : state_nxt;

            if (state != state_nxt) tcnt <= '0;
            else if (waiting)       tcnt <= tcnt + TW'(1);

            if (state_nxt == S_WR && state != S_WR) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            if (state == S_IDLE && start) begin
                data_q          <= pattern_init(seed);
                addr_q          <= BASE_ADDR;
                idx             <= '0;
                err_seen        <= 1'b0;
                err_count       <= '0;
                first_err_index <= 8'hFF;
                resp_err        <= 1'b0;
                timeout         <= 1'b0;
                done            <= 1'b0;
                pass            <= 1'b0;
                busy            <= 1'b1;
            end

            if (wr_err || rd_err) begin
                err_count <= sat_inc(err_count);
                if (wr_err || (m_axi_rresp != 2'b00)) resp_err <= 1'b1;
                if (!err_seen) begin
                    err_seen        <= 1'b1;
                    first_err_index <= idx;
                end
            end

            if (state == S_NEXT && !last_reg) begin
                idx    <= idx + 8'd1;
                addr_q <= addr_q + AW'(ADDR_STRIDE);
                data_q <= pattern_next(data_q);
            end

            if (expired) timeout <= 1'b1;

            if (state_nxt == S_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= !expired && !timeout && (err_count == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_rd_checker.sv
// Bench for axi_lite_wr_rd_checker: a configurable echo slave serves two checker
// instances (pattern mode 0 and mode 1), driven by a table of sweep scenarios.
module tb_axi_lite_wr_rd_checker;

    logic tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    logic        ARESETN;
    logic        sel;
    logic        start0, start1;
    logic [31:0] seed0, seed1;

    logic        busy0, done0, pass0, resp0, to0, busy1, done1, pass1, resp1, to1;
    logic [15:0] err0, err1;
    logic [7:0]  first0, first1;
    logic [31:0] awaddr0, wdata0, araddr0, awaddr1, wdata1, araddr1;
    logic [2:0]  awprot0, arprot0, awprot1, arprot1;
    logic [3:0]  wstrb0, wstrb1;
    logic        awvalid0, wvalid0, bready0, arvalid0, rready0;
    logic        awvalid1, wvalid1, bready1, arvalid1, rready1;

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    // Slave sees whichever master is selected; the idle one ignores responses.
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    assign m_awaddr  = sel ? awaddr1  : awaddr0;
    assign m_wdata   = sel ? wdata1   : wdata0;
    assign m_araddr  = sel ? araddr1  : araddr0;
    assign m_awvalid = sel ? awvalid1 : awvalid0;
    assign m_wvalid  = sel ? wvalid1  : wvalid0;
    assign m_bready  = sel ? bready1  : bready0;
    assign m_arvalid = sel ? arvalid1 : arvalid0;
    assign m_rready  = sel ? rready1  : rready0;

    axi_lite_wr_rd_checker #(.PATTERN_MODE(0), .TIMEOUT_CYCLES(16)) dut0 (
        .ACLK(tb_ACLK), .ARESETN(ARESETN), .start(start0), .seed(seed0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_index(first0), .resp_err(resp0), .timeout(to0),
        .m_axi_awaddr(awaddr0), .m_axi_awprot(awprot0), .m_axi_awvalid(awvalid0),
        .m_axi_awready(s_awready), .m_axi_wdata(wdata0), .m_axi_wstrb(wstrb0),
        .m_axi_wvalid(wvalid0), .m_axi_wready(s_wready), .m_axi_bresp(s_bresp),
        .m_axi_bvalid(s_bvalid), .m_axi_bready(bready0), .m_axi_araddr(araddr0),
        .m_axi_arprot(arprot0), .m_axi_arvalid(arvalid0), .m_axi_arready(s_arready),
        .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rvalid(s_rvalid),
        .m_axi_rready(rready0));

    axi_lite_wr_rd_checker #(.PATTERN_MODE(1), .TIMEOUT_CYCLES(16)) dut1 (
        .ACLK(tb_ACLK), .ARESETN(ARESETN), .start(start1), .seed(seed1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_index(first1), .resp_err(resp1), .timeout(to1),
        .m_axi_awaddr(awaddr1), .m_axi_awprot(awprot1), .m_axi_awvalid(awvalid1),
        .m_axi_awready(s_awready), .m_axi_wdata(wdata1), .m_axi_wstrb(wstrb1),
        .m_axi_wvalid(wvalid1), .m_axi_wready(s_wready), .m_axi_bresp(s_bresp),
        .m_axi_bvalid(s_bvalid), .m_axi_bready(bready1), .m_axi_araddr(araddr1),
        .m_axi_arprot(arprot1), .m_axi_arvalid(arvalid1), .m_axi_arready(s_arready),
        .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rvalid(s_rvalid),
        .m_axi_rready(rready1));

    // Slave model knobs
    int   aw_delay, flip_idx, bresp_idx;
    logic ar_block;

    logic [31:0] mem [16];
    int          aw_cnt;
    logic        aw_have, w_have;
    logic [31:0] aw_lat, w_lat;
    logic        aw_hs, w_hs;
    logic [3:0]  widx;
    logic [31:0] wdat;

    assign s_awready = m_awvalid && (aw_cnt == aw_delay);
    assign s_wready  = 1'b1;
    assign s_arready = !ar_block;
    assign aw_hs     = m_awvalid && s_awready;
    assign w_hs      = m_wvalid && s_wready;
    assign widx      = aw_hs ? m_awaddr[5:2] : aw_lat[5:2];
    assign wdat      = w_hs ? m_wdata : w_lat;

    always @(posedge tb_ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; aw_have <= 1'b0; w_have <= 1'b0; aw_lat <= '0; w_lat <= '0;
            s_bvalid <= 1'b0; s_bresp <= 2'b00;
            s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= 2'b00;
        end else begin
            if (aw_hs) aw_cnt <= 0;
            else if (m_awvalid) aw_cnt <= aw_cnt + 1;
            if (aw_hs) begin aw_have <= 1'b1; aw_lat <= m_awaddr; end
            if (w_hs)  begin w_have  <= 1'b1; w_lat  <= m_wdata;  end
            if (s_bvalid && m_bready) s_bvalid <= 1'b0;
            if ((aw_hs || aw_have) && (w_hs || w_have)) begin
                mem[widx] <= wdat;
                s_bvalid  <= 1'b1;
                s_bresp   <= (int'(widx) == bresp_idx) ? 2'b10 : 2'b00;
                aw_have   <= 1'b0;
                w_have    <= 1'b0;
            end
            if (s_rvalid && m_rready) s_rvalid <= 1'b0;
            if (m_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rresp  <= 2'b00;
                s_rdata  <= mem[m_araddr[5:2]] ^
                            ((int'(m_araddr[5:2]) == flip_idx) ? 32'h1 : 32'h0);
            end
        end
    end

    // Bus activity log
    logic [31:0] aw_log [64];
    logic [31:0] w_log  [64];
    int aw_n = 0, w_n = 0, ar_hi = 0, split = 0;
    always @(posedge tb_ACLK) begin
        if (aw_hs) begin aw_log[aw_n % 64] <= m_awaddr; aw_n <= aw_n + 1; end
        if (w_hs)  begin w_log[w_n % 64]   <= m_wdata;  w_n  <= w_n + 1;  end
        if (m_arvalid) ar_hi <= ar_hi + 1;
        if (m_awvalid && !m_wvalid) split <= split + 1;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_sweep(input logic which, input logic [31:0] s, output int cycles);
        @(negedge tb_ACLK);
        if (which) begin seed1 = s; start1 = 1'b1; end
        else       begin seed0 = s; start0 = 1'b1; end
        @(negedge tb_ACLK);
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_after_start", which ? busy1 : busy0, 1'b1);
        cycles = 0;
        while (!(which ? done1 : done0) && cycles < 2000) begin
            @(negedge tb_ACLK);
            cycles++;
        end
        if (cycles >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL sweep_done_wait: got no done, expected done within 2000 cycles");
        end
    endtask

    typedef struct {
        logic [31:0] seed;
        int          aw_delay, flip_idx, bresp_idx;
        logic        ar_block;
        int          exp_cycles, exp_writes, exp_ar_hi, exp_split;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [7:0]  exp_first;
        logic        exp_resp, exp_to;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cyc, sa, sw, sar, ssp;
        logic [31:0] expw;

        vecs[0] = '{32'h0101FFFF, 0, -1, -1, 1'b0, 20, 4, 4,  0, 1'b1, 16'd0, 8'hFF, 1'b0, 1'b0};
        vecs[1] = '{32'h12345678, 0,  2, -1, 1'b0, 20, 4, 4,  0, 1'b0, 16'd1, 8'd2,  1'b0, 1'b0};
        vecs[2] = '{32'hA0000000, 5, -1, -1, 1'b0, 40, 4, 4, 20, 1'b1, 16'd0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{32'h000000F0, 0, -1,  1, 1'b0, 20, 4, 4,  0, 1'b0, 16'd1, 8'd1,  1'b1, 1'b0};
        vecs[4] = '{32'hCAFE0000, 0, -1, -1, 1'b1, 18, 1, 16, 0, 1'b0, 16'd0, 8'hFF, 1'b0, 1'b1};

        ARESETN = 1'b0; sel = 1'b0; start0 = 1'b0; start1 = 1'b0; seed0 = '0; seed1 = '0;
        aw_delay = 0; flip_idx = -1; bresp_idx = -1; ar_block = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_pass", pass0, 1'b0);
        check("rst_err_count", err0, 16'd0);
        check("rst_first_err", first0, 8'hFF);
        check("rst_valids", {awvalid0, wvalid0, bready0, arvalid0, rready0}, 5'b0);
        check("rst_addr_data", {awaddr0, wdata0}, 64'd0);
        ARESETN = 1'b1;

        for (int i = 0; i < 5; i++) begin
            aw_delay = vecs[i].aw_delay; flip_idx = vecs[i].flip_idx;
            bresp_idx = vecs[i].bresp_idx; ar_block = vecs[i].ar_block;
            sa = aw_n; sw = w_n; sar = ar_hi; ssp = split;
            run_sweep(1'b0, vecs[i].seed, cyc);
            $display("[TB] vector %0d: %0d cycles", i, cyc);
            check("cycles", cyc, vecs[i].exp_cycles);
            check("done", done0, 1'b1);
            check("busy_end", busy0, 1'b0);
            check("pass", pass0, vecs[i].exp_pass);
            check("err_count", err0, vecs[i].exp_err);
            check("first_err_index", first0, vecs[i].exp_first);
            check("resp_err", resp0, vecs[i].exp_resp);
            check("timeout", to0, vecs[i].exp_to);
            check("arvalid_end", arvalid0, 1'b0);
            check("aw_handshakes", aw_n - sa, vecs[i].exp_writes);
            check("w_handshakes", w_n - sw, vecs[i].exp_writes);
            check("arvalid_cycles", ar_hi - sar, vecs[i].exp_ar_hi);
            check("aw_without_w_cycles", split - ssp, vecs[i].exp_split);
            for (int k = 0; k < vecs[i].exp_writes; k++) begin
                expw = vecs[i].seed + k;
                check("wdata", w_log[(sw + k) % 64], expw);
                check("awaddr", aw_log[(sa + k) % 64], 32'(4 * k));
            end
        end

        // Reset asserted while register 1's write is being presented
        aw_delay = 0; flip_idx = -1; bresp_idx = -1; ar_block = 1'b0;
        sa = aw_n;
        @(negedge tb_ACLK);
        seed0 = 32'h00000010; start0 = 1'b1;
        @(negedge tb_ACLK);
        start0 = 1'b0;
        cyc = 0;
        while (!(aw_n == sa + 1 && m_awvalid) && cyc < 50) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check("reach_reg1_wr", cyc < 50, 1'b1);
        check("reg1_awaddr", awaddr0, 32'h4);
        ARESETN = 1'b0;
        #1;
        check("rst_mid_awvalid", awvalid0, 1'b0);
        check("rst_mid_wvalid", wvalid0, 1'b0);
        check("rst_mid_busy", busy0, 1'b0);
        check("rst_mid_first", first0, 8'hFF);
        @(negedge tb_ACLK);
        ARESETN = 1'b1;
        check("rst_mid_no_aw", aw_n, sa + 1);

        // Mode-1 sweep with seed 0 on the second instance
        sel = 1'b1;
        sw = w_n;
        run_sweep(1'b1, 32'h0, cyc);
        check("lfsr_cycles", cyc, 20);
        check("lfsr_w0", w_log[sw % 64], 32'h00000001);
        check("lfsr_w1", w_log[(sw + 1) % 64], 32'h80200003);
        check("lfsr_w2", w_log[(sw + 2) % 64], 32'hC0300002);
        check("lfsr_pass", pass1, 1'b1);
        check("lfsr_err_count", err1, 16'd0);
        check("lfsr_first", first1, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
